// File: rtl/struct_rec_pkg.sv
// Shared types for the 15-bit record link.
// Used by both the serializer and the deserializer.
package struct_rec_pkg;

  localparam int E0_W = 1;
  localparam int E1_W = 2;
  localparam int E2_W = 4;
  localparam int E3_W = 8;

  typedef struct packed {
    logic [E0_W-1:0] e0;
    logic [E1_W-1:0] e1;
    logic [E2_W-1:0] e2;
    logic [E3_W-1:0] e3;
  } rec_t;

  localparam int REC_W = $bits(rec_t);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REC_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/struct_rec_deser_if.sv
// Serial input stream plus packed-record output buffer.
// master drives bits and ready, slave is the deserializer.
interface struct_rec_deser_if;
  import struct_rec_pkg::*;

  logic in_valid;
  logic in_bit;
  logic in_sof;
  logic out_valid;
  logic out_ready;
  rec_t out_rec;

  modport master (
    output in_valid, in_bit, in_sof, out_ready,
    input  out_valid, out_rec
  );

  modport slave (
    input  in_valid, in_bit, in_sof, out_ready,
    output out_valid, out_rec
  );

endinterface

// File: rtl/struct_rec_field_rev.sv
// Optional in-place bit reversal of e1/e2/e3.
// e0 passes through; shared with the serializer.
module struct_rec_field_rev
  import struct_rec_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  rec_t rec_i,
  output rec_t rec_o
);

  // reverse each multi-bit field when enabled
  always_comb begin
    rec_o = rec_i;
    if (EN) begin
      for (int i = 0; i < E1_W; i++)
        rec_o.e1[i] = rec_i.e1[E1_W-1-i];
      for (int i = 0; i < E2_W; i++)
        rec_o.e2[i] = rec_i.e2[E2_W-1-i];
      for (int i = 0; i < E3_W; i++)
        rec_o.e3[i] = rec_i.e3[E3_W-1-i];
    end
  end

endmodule

// File: rtl/struct_rec_deser.sv
// Serial-to-packed record receiver with a one-entry
// valid/ready output buffer and sticky error flags.
module struct_rec_deser
  import struct_rec_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FIELD_ASC = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  struct_rec_deser_if.slave  io,
  input  logic               clr_err,
  output logic               overrun,
  output logic               frame_err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REC_W-1:0]   sh_q, sh_d;
  logic               vld_q, vld_d;
  rec_t               rec_q, rec_d;
  logic               ovr_q, ovr_d;
  logic               fe_q, fe_d;

  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   idx0;
  logic [REC_W-1:0]   full;
  logic               done;
  logic               fe_ev;
  logic               ov_ev;
  rec_t               rec_new;

  assign idx0 = MSB_FIRST ? LAST : '0;
  assign idx  = MSB_FIRST ? LAST - cnt_q : cnt_q;

  // shift register with the current bit merged in
  always_comb begin
    full      = sh_q;
    full[idx] = io.in_bit;
  end

  struct_rec_field_rev #(
    .EN (FIELD_ASC)
  ) u_rev (
    .rec_i (rec_t'(full)),
    .rec_o (rec_new)
  );

  // frame assembly: sof restarts, 15th bit completes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    done    = 1'b0;
    fe_ev   = 1'b0;
    if (io.in_valid) begin
      if (io.in_sof) begin
        fe_ev      = (state_q == SHIFT);
        sh_d       = '0;
        sh_d[idx0] = io.in_bit;
        cnt_d      = CNT_W'(1);
        state_d    = SHIFT;
      end else if (state_q == SHIFT) begin
        if (cnt_q == LAST) begin
          done    = 1'b1;
          sh_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          sh_d  = full;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // output buffer and sticky flags; set beats clear
  always_comb begin
    vld_d = vld_q;
    rec_d = rec_q;
    ov_ev = 1'b0;
    if (vld_q && io.out_ready)
      vld_d = 1'b0;
    if (done) begin
      if (!vld_q || io.out_ready) begin
        vld_d = 1'b1;
        rec_d = rec_new;
      end else begin
        ov_ev = 1'b1;
      end
    end
    ovr_d = (ovr_q & ~clr_err) | ov_ev;
    fe_d  = (fe_q & ~clr_err) | fe_ev;
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      vld_q   <= 1'b0;
      rec_q   <= '0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      vld_q   <= vld_d;
      rec_q   <= rec_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  assign io.out_valid = vld_q;
  assign io.out_rec   = rec_q;
  assign overrun      = ovr_q;
  assign frame_err    = fe_q;

endmodule

// File: tb/tb_struct_rec_deser.sv
// Bench for struct_rec_deser: three parameter sets
// driven with one stream, checked against a frame model.
module tb_struct_rec_deser;
  import struct_rec_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_err = 1'b0;
  logic ovr0, ovr1, ovr2;
  logic fe0, fe1, fe2;

  struct_rec_deser_if i0 ();
  struct_rec_deser_if i1 ();
  struct_rec_deser_if i2 ();

  struct_rec_deser #(.MSB_FIRST(1'b1), .FIELD_ASC(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .io(i0.slave),
    .clr_err(clr_err), .overrun(ovr0), .frame_err(fe0));
  struct_rec_deser #(.MSB_FIRST(1'b1), .FIELD_ASC(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .io(i1.slave),
    .clr_err(clr_err), .overrun(ovr1), .frame_err(fe1));
  struct_rec_deser #(.MSB_FIRST(1'b0), .FIELD_ASC(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .io(i2.slave),
    .clr_err(clr_err), .overrun(ovr2), .frame_err(fe2));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          fb[$];
  bit          in_frame;
  bit          mv[3];
  logic [14:0] mrec[3];
  bit          mov[3];
  bit          mfe;

  function automatic logic [7:0] rev(input logic [7:0] x, input int w);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < w; i++) y[i] = x[w-1-i];
    return y;
  endfunction

  // f[k] is the k-th received bit of the frame
  function automatic logic [14:0] build(input logic [14:0] f,
                                        input bit msb, input bit fa);
    logic [14:0] r;
    logic [7:0] a, b, c;
    r = '0;
    for (int k = 0; k < 15; k++) begin
      if (msb) r[14-k] = f[k];
      else     r[k]    = f[k];
    end
    if (fa) begin
      a = rev({6'b0, r[13:12]}, 2);
      b = rev({4'b0, r[11:8]}, 4);
      c = rev(r[7:0], 8);
      r = {r[14], a[1:0], b[3:0], c};
    end
    return r;
  endfunction

  task automatic model_reset();
    fb.delete();
    in_frame = 1'b0;
    mfe = 1'b0;
    for (int d = 0; d < 3; d++) begin
      mv[d] = 1'b0; mrec[d] = '0; mov[d] = 1'b0;
    end
  endtask

  task automatic model_edge(bit v, bit b, bit s, bit r, bit clr);
    bit done, fe_ev, ov, nv;
    logic [14:0] f;
    done = 1'b0; fe_ev = 1'b0; f = '0;
    if (v) begin
      if (s) begin
        fe_ev = in_frame;
        fb.delete();
        fb.push_back(b);
        in_frame = 1'b1;
      end else if (in_frame) begin
        fb.push_back(b);
        if (fb.size() == 15) begin
          done = 1'b1;
          for (int k = 0; k < 15; k++) f[k] = fb[k];
          fb.delete();
          in_frame = 1'b0;
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      ov = 1'b0;
      nv = mv[d] && !r;
      if (done) begin
        if (!mv[d] || r) begin
          nv = 1'b1;
          mrec[d] = build(f, d != 2, d == 1);
        end else begin
          ov = 1'b1;
        end
      end
      mv[d] = nv;
      mov[d] = (mov[d] && !clr) || ov;
    end
    mfe = (mfe && !clr) || fe_ev;
  endtask

  task automatic chk(string nm, logic [14:0] a, logic [14:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic compare_all();
    chk("v0", 15'(i0.out_valid), 15'(mv[0]));
    chk("v1", 15'(i1.out_valid), 15'(mv[1]));
    chk("v2", 15'(i2.out_valid), 15'(mv[2]));
    chk("rec0", i0.out_rec, mrec[0]);
    chk("rec1", i1.out_rec, mrec[1]);
    chk("rec2", i2.out_rec, mrec[2]);
    chk("ovr0", 15'(ovr0), 15'(mov[0]));
    chk("ovr1", 15'(ovr1), 15'(mov[1]));
    chk("ovr2", 15'(ovr2), 15'(mov[2]));
    chk("fe0", 15'(fe0), 15'(mfe));
    chk("fe1", 15'(fe1), 15'(mfe));
    chk("fe2", 15'(fe2), 15'(mfe));
  endtask

  task automatic drive(bit v, bit b, bit s, bit r, bit clr);
    i0.in_valid = v; i0.in_bit = b; i0.in_sof = s; i0.out_ready = r;
    i1.in_valid = v; i1.in_bit = b; i1.in_sof = s; i1.out_ready = r;
    i2.in_valid = v; i2.in_bit = b; i2.in_sof = s; i2.out_ready = r;
    clr_err = clr;
  endtask

  task automatic step(bit v, bit b, bit s, bit r, bit clr);
    drive(v, b, s, r, clr);
    @(posedge clk);
    model_edge(v, b, s, r, clr);
    #1;
    compare_all();
  endtask

  task automatic send_frame(logic [14:0] rec, bit msb, bit r, bit stall);
    bit b;
    for (int k = 0; k < 15; k++) begin
      if (stall && k > 0) step(1'b0, 1'b0, 1'b0, r, 1'b0);
      b = msb ? rec[14-k] : rec[k];
      step(1'b1, b, k == 0, r, 1'b0);
    end
  endtask

  typedef struct {
    bit v, b, s, r;
    bit ev;
    logic [14:0] er0;
    logic [14:0] er1;
  } vec_t;

  vec_t tbl[17];
  logic [14:0] st;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // basic frame and field reversal, table driven
    st = 15'h6A5C;
    for (int k = 0; k < 15; k++)
      tbl[k] = '{1'b1, st[14-k], k == 0, 1'b1, k == 14,
                 (k == 14) ? 15'h6A5C : 15'h0,
                 (k == 14) ? 15'h553A : 15'h0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'h6A5C, 15'h553A};
    tbl[16] = tbl[15];
    for (int k = 0; k < 17; k++) begin
      step(tbl[k].v, tbl[k].b, tbl[k].s, tbl[k].r, 1'b0);
      chk("tbl_v", 15'(i0.out_valid), 15'(tbl[k].ev));
      chk("tbl_rec", i0.out_rec, tbl[k].er0);
      chk("tbl_asc", i1.out_rec, tbl[k].er1);
    end

    // LSB-first with stalls
    send_frame(15'h6A5C, 1'b0, 1'b1, 1'b1);
    chk("lsb_v", 15'(i2.out_valid), 15'd1);
    chk("lsb_rec", i2.out_rec, 15'h6A5C);
    chk("lsb_fe", 15'(fe2), 15'd0);
    chk("lsb_ovr", 15'(ovr2), 15'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // overrun: second frame dropped while buffer held
    send_frame(15'h6A5C, 1'b1, 1'b0, 1'b0);
    send_frame(15'h1234, 1'b1, 1'b0, 1'b0);
    chk("ovr_rec", i0.out_rec, 15'h6A5C);
    chk("ovr_set", 15'(ovr0), 15'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_drain", 15'(i0.out_valid), 15'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_once", 15'(i0.out_valid), 15'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 15'(ovr0), 15'd0);

    // resync: sof at bit 7 of a pending frame
    for (int k = 0; k < 7; k++)
      step(1'b1, 1'($urandom), k == 0, 1'b1, 1'b0);
    chk("rs_nov", 15'(i0.out_valid), 15'd0);
    send_frame(15'h7FFF, 1'b1, 1'b1, 1'b0);
    chk("rs_fe", 15'(fe0), 15'd1);
    chk("rs_v", 15'(i0.out_valid), 15'd1);
    chk("rs_rec", i0.out_rec, 15'h7FFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rs_clr", 15'(fe0), 15'd0);

    // reset at bit 9 with a record held
    send_frame(15'h2AAA, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++)
      step(1'b1, 1'($urandom), k == 0, 1'b0, 1'b0);
    chk("rm_pre", 15'(i0.out_valid), 15'd1);
    #1 rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    chk("rm_v", 15'(i0.out_valid), 15'd0);
    chk("rm_rec", i0.out_rec, 15'h0);
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(15'h0001, 1'b1, 1'b1, 1'b0);
    chk("rm_post_v", 15'(i0.out_valid), 15'd1);
    chk("rm_post_rec", i0.out_rec, 15'h0001);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      bit v, b, s, r, c;
      v = $urandom_range(0, 3) != 0;
      b = 1'($urandom);
      s = in_frame ? ($urandom_range(0, 39) == 0)
                   : ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 2) != 0;
      c = $urandom_range(0, 30) == 0;
      step(v, b, s, r, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
